// File: rtl/parity_counter_arbiter_pkg.sv
// Shared types and constants for the parity counter arbiter slice.
package pcarb_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_STEPW = 4;
  localparam int STEP      = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Round-robin pick between two requesters; only meaningful when req != 0.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    case (req)
      2'b01:   pick = REQ0;
      2'b10:   pick = REQ1;
      default: pick = ~last_grant;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/parity_counter_arbiter_if.sv
// Request/grant/count bundle between the two requesters and the arbiter.
interface parity_counter_arbiter_if
  import pcarb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPW = DEF_STEPW
) ();

  logic [1:0]       req;
  logic [1:0]       req_dir;
  logic [1:0]       req_even;
  logic [STEPW-1:0] req_steps0;
  logic [STEPW-1:0] req_steps1;

  logic [1:0]       grant;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] count;

  modport master (
    output req, req_dir, req_even, req_steps0, req_steps1,
    input  grant, busy, done, done_id, count
  );

  modport slave (
    input  req, req_dir, req_even, req_steps0, req_steps1,
    output grant, busy, done, done_id, count
  );

endinterface

// File: rtl/parity_step_counter.sv
// Count register: +1 parity correction when aligning, +/-STEP when stepping.
// One-cycle update; align takes precedence over step.
module parity_step_counter
  import pcarb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             align_en_i,
  input  logic             target_even_i,
  input  logic             step_en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             parity_miss;

  // Even target wants bit0 clear, so a miss is bit0 equal to target_even.
  assign parity_miss = (count_q[0] == target_even_i);

  always_comb begin
    count_d = count_q;
    if (align_en_i) begin
      if (parity_miss) begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (step_en_i) begin
      count_d = dir_i ? (count_q + WIDTH'(STEP)) : (count_q - WIDTH'(STEP));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/parity_counter_arbiter.sv
// Round-robin owner of a shared even/odd step counter: align parity, step N times, pulse done.
// Run latency N+2 cycles from acceptance to done; requests are only sampled in IDLE.
module parity_counter_arbiter
  import pcarb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPW = DEF_STEPW
) (
  input  logic                     clk,
  input  logic                     reset,
  parity_counter_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             dir_q, dir_d;
  logic             even_q, even_d;
  logic [STEPW-1:0] steps_q, steps_d;

  logic             winner;
  logic             align_en;
  logic             step_en;
  logic [WIDTH-1:0] count;

  assign winner = rr_pick(bus.req, last_grant_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dir_d        = dir_q;
    even_d       = even_q;
    steps_d      = steps_q;
    align_en     = 1'b0;
    step_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          owner_d = winner;
          dir_d   = bus.req_dir[winner];
          even_d  = bus.req_even[winner];
          steps_d = winner ? bus.req_steps1 : bus.req_steps0;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        align_en = 1'b1;
        state_d  = (steps_q != '0) ? RUN : DONE;
      end
      RUN: begin
        step_en = 1'b1;
        steps_d = steps_q - STEPW'(1);
        if (steps_q == STEPW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to REQ1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= REQ0;
      last_grant_q <= REQ1;
      dir_q        <= 1'b0;
      even_q       <= 1'b0;
      steps_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dir_q        <= dir_d;
      even_q       <= even_d;
      steps_q      <= steps_d;
    end
  end

  parity_step_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .align_en_i    (align_en),
    .target_even_i (even_q),
    .step_en_i     (step_en),
    .dir_i         (dir_q),
    .count_o       (count)
  );

  assign bus.busy    = (state_q != IDLE);
  assign bus.grant   = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign bus.done    = (state_q == DONE);
  assign bus.done_id = (state_q == DONE) & owner_q;
  assign bus.count   = count;

endmodule

// File: tb/tb_parity_counter_arbiter.sv
// Directed bench for parity_counter_arbiter with hand-computed expected counts.
module tb_parity_counter_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   t;
  bit   exp_owner [3] = '{1'b0, 1'b1, 1'b0};

  parity_counter_arbiter_if #(.WIDTH(4), .STEPW(4)) bus ();

  parity_counter_arbiter #(.WIDTH(4), .STEPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts and checks one single-requester run; entered and left at a negedge in IDLE.
  task automatic do_run(input bit id, input bit even, input bit up, input int steps,
                        input logic [3:0] exp_align, input logic [3:0] exp_last);
    logic [3:0] c;
    bus.req        = 2'b00;
    bus.req[id]    = 1'b1;
    bus.req_even   = {even, even};
    bus.req_dir    = {up, up};
    bus.req_steps0 = 4'(steps);
    bus.req_steps1 = 4'(steps);
    @(negedge clk);
    chk("acc_grant", bus.grant, id ? 2 : 1);
    chk("acc_busy", bus.busy, 1);
    // Scramble inputs mid-run; latched values must be used.
    bus.req        = 2'b00;
    bus.req_even   = {~even, ~even};
    bus.req_dir    = {~up, ~up};
    bus.req_steps0 = 4'hf;
    bus.req_steps1 = 4'hf;
    @(negedge clk);
    chk("align_count", bus.count, exp_align);
    chk("align_done", bus.done, (steps == 0) ? 1 : 0);
    c = exp_align;
    for (int i = 0; i < steps; i++) begin
      @(negedge clk);
      c = up ? c + 4'd2 : c - 4'd2;
      chk("step_count", bus.count, c);
      chk("step_done", bus.done, (i == steps - 1) ? 1 : 0);
    end
    chk("last_count", bus.count, exp_last);
    chk("done_id", bus.done_id, id);
    chk("done_grant", bus.grant, id ? 2 : 1);
    @(negedge clk);
    chk("idle_grant", bus.grant, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_count", bus.count, exp_last);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    clk            = 1'b0;
    reset          = 1'b1;
    bus.req        = 2'b00;
    bus.req_dir    = 2'b00;
    bus.req_even   = 2'b00;
    bus.req_steps0 = '0;
    bus.req_steps1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_done_id", bus.done_id, 0);
    reset = 1'b0;

    do_run(1'b0, 1'b1, 1'b1, 3, 4'd0, 4'd6);
    do_run(1'b1, 1'b0, 1'b0, 2, 4'd7, 4'd3);
    do_run(1'b0, 1'b1, 1'b1, 5, 4'd4, 4'd14);
    do_run(1'b0, 1'b1, 1'b1, 2, 4'd14, 4'd2);
    do_run(1'b1, 1'b0, 1'b0, 1, 4'd3, 4'd1);
    do_run(1'b0, 1'b0, 1'b0, 1, 4'd1, 4'd15);
    do_run(1'b1, 1'b1, 1'b1, 2, 4'd0, 4'd4);
    do_run(1'b0, 1'b0, 1'b1, 0, 4'd5, 4'd5);

    // Contention with both requests held: 0, 1, 0.
    reset = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    bus.req        = 2'b11;
    bus.req_even   = 2'b11;
    bus.req_dir    = 2'b11;
    bus.req_steps0 = 4'd1;
    bus.req_steps1 = 4'd1;
    for (int r = 0; r < 3; r++) begin
      t = 0;
      while (!bus.busy && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk("rr_grant", bus.grant, exp_owner[r] ? 2 : 1);
      t = 0;
      while (!bus.done && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk("rr_done", bus.done, 1);
      chk("rr_done_id", bus.done_id, exp_owner[r]);
      chk("rr_count", bus.count, 2 * (r + 1));
      if (r == 2) bus.req = 2'b00;
      @(negedge clk);
    end

    // Reset in the middle of a requester-1 run.
    bus.req        = 2'b10;
    bus.req_steps1 = 4'd5;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("mid_count", bus.count, 8);
    chk("mid_grant", bus.grant, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_count", bus.count, 0);
    chk("mrst_grant", bus.grant, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    reset          = 1'b0;
    bus.req        = 2'b11;
    bus.req_steps0 = 4'd1;
    bus.req_steps1 = 4'd1;
    @(negedge clk);
    chk("post_rst_grant", bus.grant, 1);
    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", bus.grant, 0);
    chk("post_rst_count", bus.count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parity_counter_arbiter.md
Name: parity_counter_arbiter

Overview:
- Shares a single even/odd step counter between two requesters.
- Each requester asks for a run: parity (even/odd), direction (up/down) and a step count.
- The block arbitrates round-robin, aligns the counter to the requested parity, steps it by 2 per cycle for N steps, then signals completion.
- Sits between the control requesters and the counter datapath; it is the only writer of the count.

Parameters:
- WIDTH, 4, count register width; count wraps modulo 2^WIDTH.
- STEPW, 4, width of each requester's step-count field.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req  input  2  per-requester run request; level, sampled only in IDLE.
- req_dir  input  2  per-requester direction; 1 = up (+2), 0 = down (-2).
- req_even  input  2  per-requester parity; 1 = even, 0 = odd.
- req_steps0  input  STEPW  step count for requester 0.
- req_steps1  input  STEPW  step count for requester 1.
- grant  output  2  one-hot owner of the counter; all-zero when idle.
- busy  output  1  high whenever grant is non-zero.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  index of the requester whose run finished; valid while done=1.
- count  output  WIDTH  current counter value.

Behaviour:
- Reset: count=0, grant=0, busy=0, done=0, done_id=0, state=IDLE, last_grant=1 (so requester 0 wins first).
- Reset mid-run: abort the run immediately and return everything to reset values; no done pulse.
- FSM states: IDLE, ALIGN, RUN, DONE. grant and busy are asserted in ALIGN, RUN and DONE; done is high only in DONE.
- IDLE:
  - Only one req bit set: that requester wins.
  - Both set: the requester other than last_grant wins.
  - On the winning edge: latch dir, even and steps into run registers, set grant one-hot, go to ALIGN.
  - No req: hold; count holds.
- ALIGN (exactly 1 cycle):
  - If count[0] does not match the latched parity (even → count[0]=0), count <= count+1, modulo 2^WIDTH. Otherwise count holds.
  - Next state: RUN if latched steps > 0, else DONE.
- RUN:
  - Every cycle, count <= count ± 2 modulo 2^WIDTH. Wrap is silent and preserves parity.
  - Remaining step count decrements each cycle. The edge that performs the last step moves the FSM to DONE.
- DONE (1 cycle):
  - done=1, done_id = owner index, count holds.
  - Next edge: grant cleared, last_grant <= owner, state <= IDLE.
- Latency: request accepted at edge k → first step at edge k+2 → last step at edge k+1+N → done high during cycle k+1+N..k+2+N. Earliest next grant is at edge k+3+N (one IDLE cycle between runs).
- Inputs are ignored outside IDLE. Changing or dropping req, dir, even or steps mid-run has no effect; latched values are used.
- A requester that holds req after its own done is eligible again. Round-robin guarantees the other pending requester is served first.

Decomposition:
- Shared package pcarb_pkg holds:
  - FSM state enum (IDLE/ALIGN/RUN/DONE);
  - default WIDTH/STEPW constants;
  - requester index constants REQ0=0, REQ1=1;
  - step increment constant STEP=2.
- Sub-module parity_step_counter holds the count register.
  - Inputs: align_en, target_even, step_en, dir.
  - Performs the +1 parity correction or the ±2 step.
  - The arbiter FSM drives it and never writes count directly.

Test Plan:
- Basic up run: reset; req=01, even=1, dir=1, steps0=3 from count=0 → ALIGN leaves 0; count steps 2,4,6; done=1 with done_id=0; grant returns to 00 one cycle later.
- Odd down run: from count=6, req=10, even=0, dir=0, steps1=2 → ALIGN gives 7, then 5, 3; done_id=1.
- Simultaneous requests: after reset, req=11 held, steps=1 each → grant 01 first, done_id=0; then grant 10, done_id=1; then grant 01 again (round-robin alternation).
- Wrap: count=14, even up, steps=2 → 0, 2. Count=1, odd down, steps=1 → 15.
- Zero steps: count=4, odd, steps=0 → ALIGN gives 5, then DONE directly; done asserts 2 cycles after acceptance.
- Reset mid-run: assert reset during RUN → next edge count=0, grant=0, done=0, state IDLE; requester 0 has priority on the next contention.
